shl_seq: RTL and testbench

//   Sequential logical left shifter: opposite direction of the combinational right-shift component.

---
 rtl/shl_seq.sv | 92 +++++++++
 tb/tb_shl_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shl_seq.sv
// Sequential logical left shifter: shifts a by sh_amt, up to STEP bits per cycle,
// behind a start/busy/done handshake. The result is held on d between operations.
module shl_seq #(
  parameter int DATAWIDTH = 2,
  parameter int STEP      = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic [DATAWIDTH-1:0] d,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = $clog2(DATAWIDTH + 1);
  localparam logic [RW-1:0]      LP_DW     = RW'(DATAWIDTH);
  localparam logic [RW-1:0]      LP_STEP   = RW'(STEP);
  localparam logic [DATAWIDTH:0] LP_DW_EXT = (DATAWIDTH + 1)'(DATAWIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [DATAWIDTH-1:0] r_acc;
  logic [DATAWIDTH-1:0] w_nextAcc;
  logic [DATAWIDTH-1:0] r_d;
  logic [DATAWIDTH-1:0] w_nextD;
  logic [RW-1:0]        r_rem;
  logic [RW-1:0]        w_nextRem;
  logic [RW-1:0]        w_clampAmt;
  logic [RW-1:0]        w_stepAmt;
  logic                 w_shGeDw;

  // Amounts at or beyond the width collapse to DATAWIDTH, so rem always fits RW bits.
  assign w_shGeDw   = ({1'b0, sh_amt} >= LP_DW_EXT);
  assign w_clampAmt = w_shGeDw ? LP_DW : sh_amt[RW-1:0];
  assign w_stepAmt  = (r_rem < LP_STEP) ? r_rem : LP_STEP;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_nextState;
      r_acc   <= w_nextAcc;
      r_rem   <= w_nextRem;
      r_d     <= w_nextD;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextAcc   = r_acc;
    w_nextRem   = r_rem;
    w_nextD     = r_d;
    case (r_state)
      // DONE accepts a new request exactly like IDLE, allowing back-to-back ops.
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nextAcc   = a;
          w_nextRem   = w_clampAmt;
          w_nextState = S_SHIFT;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_rem == '0) begin
          w_nextD     = r_acc;
          w_nextState = S_DONE;
        end else begin
          w_nextAcc = r_acc << w_stepAmt;
          w_nextRem = r_rem - w_stepAmt;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign d    = r_d;
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_shl_seq.sv
// Self-checking bench for shl_seq: three instances (8-bit STEP=1, 8-bit STEP=3,
// 2-bit default), table-driven vectors plus a scoreboard of expected results.
module tb_shl_seq;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       start0, start1, start2;
  logic [7:0] a0, sh0, a1, sh1;
  logic [1:0] a2, sh2;
  logic [7:0] d0, d1;
  logic [1:0] d2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         unit;
    logic [7:0] expD;
    int         expN;
    int         doneCyc;
  } sbRec_t;

  typedef struct {
    int         unit;
    logic [7:0] a;
    logic [7:0] sh;
    logic [7:0] expD;
    int         expN;
  } vec_t;

  sbRec_t     sbQ[$];
  sbRec_t     rec;
  vec_t       vecs[11];
  logic [7:0] lastD[3];
  int         busyRun[3];

  shl_seq #(.DATAWIDTH(8), .STEP(1)) u0 (
    .Clk(Clk), .Rst(Rst), .start(start0), .a(a0), .sh_amt(sh0),
    .d(d0), .busy(busy0), .done(done0));
  shl_seq #(.DATAWIDTH(8), .STEP(3)) u1 (
    .Clk(Clk), .Rst(Rst), .start(start1), .a(a1), .sh_amt(sh1),
    .d(d1), .busy(busy1), .done(done1));
  shl_seq u2 (
    .Clk(Clk), .Rst(Rst), .start(start2), .a(a2), .sh_amt(sh2),
    .d(d2), .busy(busy2), .done(done2));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] getD(input int u);
    case (u)
      0:       return d0;
      1:       return d1;
      default: return {6'b0, d2};
    endcase
  endfunction

  function automatic logic getBusy(input int u);
    case (u)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic getDone(input int u);
    case (u)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int u, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s unit%0d: got 0x%0h expected 0x%0h (cycle %0d)",
               name, u, act, exp, cyc);
    end
  endtask

  task automatic setInputs(input int u, input logic st, input logic [7:0] av,
                           input logic [7:0] shv);
    case (u)
      0: begin start0 = st; a0 = av; sh0 = shv; end
      1: begin start1 = st; a1 = av; sh1 = shv; end
      default: begin start2 = st; a2 = av[1:0]; sh2 = shv[1:0]; end
    endcase
  endtask

  // Called just after a rising edge; start is sampled at the next edge k.
  task automatic applyStimulus(input int u, input logic [7:0] av, input logic [7:0] shv,
                               input logic [7:0] expD, input int expN);
    setInputs(u, 1'b1, av, shv);
    @(posedge Clk);
    #1;
    sbQ.push_back('{unit: u, expD: expD, expN: expN, doneCyc: cyc + expN + 1});
    setInputs(u, 1'b0, av, shv);
  endtask

  task automatic waitDone(input int u);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge Clk);
      #1;
      seen = getDone(u);
    end
    if (!seen) checkOutput("done_timeout", u, {31'b0, getDone(u)}, 32'd1);
  endtask

  task automatic runOp(input int u, input logic [7:0] av, input logic [7:0] shv,
                       input logic [7:0] expD, input int expN);
    applyStimulus(u, av, shv, expD, expN);
    waitDone(u);
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: every done must match the oldest pending op, and d must hold otherwise.
  always @(negedge Clk) begin
    if (!Rst) begin
      sbQ.delete();
      for (int u = 0; u < 3; u++) begin
        lastD[u]   = 8'h00;
        busyRun[u] = 0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (getDone(u)) begin
          if (sbQ.size() == 0 || sbQ[0].unit != u) begin
            checkOutput("spurious_done", u, {31'b0, getDone(u)}, 32'd0);
          end else begin
            rec = sbQ.pop_front();
            checkOutput("result_d", u, {24'b0, getD(u)}, {24'b0, rec.expD});
            checkOutput("done_cycle", u, cyc, rec.doneCyc);
            checkOutput("busy_cycles", u, busyRun[u], rec.expN + 1);
            lastD[u] = rec.expD;
          end
          busyRun[u] = 0;
        end else begin
          checkOutput("d_hold", u, {24'b0, getD(u)}, {24'b0, lastD[u]});
          if (getBusy(u)) busyRun[u]++;
          else busyRun[u] = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{unit: 0, a: 8'h81, sh: 8'd1,   expD: 8'h02, expN: 1};
    vecs[1]  = '{unit: 0, a: 8'h01, sh: 8'd7,   expD: 8'h80, expN: 7};
    vecs[2]  = '{unit: 0, a: 8'hFF, sh: 8'd8,   expD: 8'h00, expN: 8};
    vecs[3]  = '{unit: 0, a: 8'hFF, sh: 8'd200, expD: 8'h00, expN: 8};
    vecs[4]  = '{unit: 0, a: 8'hA5, sh: 8'd0,   expD: 8'hA5, expN: 0};
    vecs[5]  = '{unit: 1, a: 8'h0F, sh: 8'd7,   expD: 8'h80, expN: 3};
    vecs[6]  = '{unit: 1, a: 8'h5A, sh: 8'd0,   expD: 8'h5A, expN: 0};
    vecs[7]  = '{unit: 1, a: 8'hFF, sh: 8'd8,   expD: 8'h00, expN: 3};
    vecs[8]  = '{unit: 1, a: 8'hC3, sh: 8'd4,   expD: 8'h30, expN: 2};
    vecs[9]  = '{unit: 1, a: 8'h01, sh: 8'd3,   expD: 8'h08, expN: 1};
    vecs[10] = '{unit: 1, a: 8'h81, sh: 8'd255, expD: 8'h00, expN: 3};

    for (int u = 0; u < 3; u++) setInputs(u, 1'b0, 8'h00, 8'h00);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      checkOutput("reset_d", u, {24'b0, getD(u)}, 32'd0);
      checkOutput("reset_busy", u, {31'b0, getBusy(u)}, 32'd0);
      checkOutput("reset_done", u, {31'b0, getDone(u)}, 32'd0);
    end
    @(posedge Clk);
    #1;

    for (int i = 0; i < 11; i++)
      runOp(vecs[i].unit, vecs[i].a, vecs[i].sh, vecs[i].expD, vecs[i].expN);

    for (int av = 0; av < 4; av++) begin
      for (int s = 0; s < 4; s++) begin
        int eff;
        eff = (s >= 2) ? 2 : s;
        runOp(2, 8'(av), 8'(s), 8'((av << s) & 3), eff);
      end
    end

    // A start pulse with a different operand while busy must be ignored.
    applyStimulus(0, 8'h01, 8'd4, 8'h10, 4);
    @(posedge Clk);
    #1;
    setInputs(0, 1'b1, 8'hFF, 8'd1);
    @(posedge Clk);
    #1;
    setInputs(0, 1'b0, 8'h00, 8'd0);
    waitDone(0);
    @(posedge Clk);
    #1;

    // Start raised in the done cycle begins the next op immediately.
    applyStimulus(1, 8'h03, 8'd2, 8'h0C, 1);
    waitDone(1);
    applyStimulus(1, 8'h11, 8'd6, 8'h40, 2);
    waitDone(1);
    @(posedge Clk);
    #1;

    // Mid-operation reset: the pending op is abandoned and d clears.
    runOp(0, 8'h0F, 8'd3, 8'h78, 3);
    applyStimulus(0, 8'hFF, 8'd5, 8'hE0, 5);
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    checkOutput("busy_before_reset", 0, {31'b0, busy0}, 32'd1);
    Rst = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;
    repeat (3) begin
      checkOutput("post_reset_d", 0, {24'b0, d0}, 32'd0);
      checkOutput("post_reset_busy", 0, {31'b0, busy0}, 32'd0);
      checkOutput("post_reset_done", 0, {31'b0, done0}, 32'd0);
      @(posedge Clk);
      #1;
    end
    repeat (8) @(posedge Clk);
    #1;
    checkOutput("scoreboard_empty", 0, sbQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
